// File: rtl/crt_loader.sv
// Streams a .CRT cartridge image: validates the header, publishes per-CHIP bank descriptors
// and writes CHIP payloads to SDRAM at 8K-aligned offsets from DATA_BASE.
module crt_loader #(
  parameter logic [24:0] DATA_BASE = 25'h0100000,
  parameter logic [24:0] MAX_SPAN  = 25'h0100000
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        cart_loading,
  output logic        cart_attached,
  output logic [15:0] cart_id,
  output logic [7:0]  cart_exrom,
  output logic [7:0]  cart_game,
  output logic [15:0] cart_bank_num,
  output logic [7:0]  cart_bank_type,
  output logic [15:0] cart_bank_laddr,
  output logic [15:0] cart_bank_size,
  output logic [24:0] cart_bank_raddr,
  output logic        cart_bank_wr,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic [7:0]  bank_count,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, SIG, HDR, SKIP, CHIP, DATA, DONE, ERR} state_t;

  localparam logic [127:0] SIG_STR  = "C64 CARTRIDGE   ";
  localparam logic [31:0]  CHIP_STR = "CHIP";

  state_t      state, ns, nb;
  logic        act_q, rise, fall;
  logic [31:0] idx, header_len, pkt_len, remaining;
  logic [3:0]  cidx, cidx_nxt;
  logic [24:0] offset, offset_al;
  logic [7:0]  b_type, size_hi, sig_byte, chip_byte;
  logic [15:0] b_num, b_laddr;
  logic        wr_mem, desc;

  assign rise = dl_active & ~act_q;
  assign fall = ~dl_active & act_q;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= ns;
  end

  always_comb begin
    nb        = state;
    wr_mem    = 1'b0;
    desc      = 1'b0;
    cidx_nxt  = cidx;
    sig_byte  = SIG_STR[{~idx[3:0], 3'b000} +: 8];
    chip_byte = CHIP_STR[{~cidx[1:0], 3'b000} +: 8];
    offset_al = (offset + 25'h1FFF) & ~25'h1FFF;
    if (dl_wr) begin
      case (state)
        SIG: begin
          if (dl_data != sig_byte)  nb = ERR;
          else if (idx[3:0] == 4'hF) nb = HDR;
        end
        HDR: begin
          if (idx[3:0] == 4'hF) begin
            if (header_len < 32'h20)       nb = ERR;
            else if (header_len == 32'h20) nb = CHIP;
            else                           nb = SKIP;
          end
        end
        SKIP: if (idx == header_len - 32'd1) nb = CHIP;
        CHIP: begin
          cidx_nxt = cidx + 4'd1;
          if (cidx < 4'd4 && dl_data != chip_byte) nb = ERR;
          else if (cidx == 4'hF) begin
            if (pkt_len < 32'd16) nb = ERR;
            else begin
              desc = 1'b1;
              nb   = (pkt_len == 32'd16) ? CHIP : DATA;
            end
          end
        end
        DATA: begin
          // A byte that would land at MAX_SPAN is dropped, never written.
          if (offset == MAX_SPAN) nb = ERR;
          else begin
            wr_mem = 1'b1;
            if (remaining == 32'd1) nb = CHIP;
          end
        end
        default: ;
      endcase
    end
    ns = nb;
    // The byte arriving with the falling edge is folded in before termination is judged.
    if (rise)                                             ns = SIG;
    else if (state == DONE || (state == ERR && !dl_active)) ns = IDLE;
    else if (fall && state != IDLE)
      ns = (nb == CHIP && cidx_nxt == 4'd0) ? DONE : ERR;
  end

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      act_q <= 1'b0;  idx <= '0;  cidx <= '0;  header_len <= '0;  pkt_len <= '0;
      remaining <= '0;  offset <= '0;  b_type <= '0;  size_hi <= '0;  b_num <= '0;
      b_laddr <= '0;  cart_loading <= 1'b0;  cart_attached <= 1'b0;  cart_id <= '0;
      cart_exrom <= '0;  cart_game <= '0;  cart_bank_num <= '0;  cart_bank_type <= '0;
      cart_bank_laddr <= '0;  cart_bank_size <= '0;  cart_bank_raddr <= '0;
      cart_bank_wr <= 1'b0;  mem_addr <= '0;  mem_data <= '0;  mem_wr <= 1'b0;
      bank_count <= '0;  error <= 1'b0;
    end else begin
      act_q        <= dl_active;
      mem_wr       <= 1'b0;
      cart_bank_wr <= 1'b0;
      if (rise) begin
        cart_attached <= 1'b0;
        error         <= 1'b0;
        bank_count    <= '0;
        offset        <= '0;
        idx           <= '0;
        cidx          <= '0;
        cart_loading  <= 1'b1;
      end else begin
        if (dl_wr && (state == SIG || state == HDR || state == SKIP)) idx <= idx + 32'd1;
        if (dl_wr && state == HDR) begin
          case (idx[3:0])
            4'h0, 4'h1, 4'h2, 4'h3: header_len <= {header_len[23:0], dl_data};
            4'h6:    cart_id[15:8] <= dl_data;
            4'h7:    cart_id[7:0]  <= dl_data;
            4'h8:    cart_exrom    <= dl_data;
            4'h9:    cart_game     <= dl_data;
            default: ;
          endcase
        end
        if (dl_wr && state == CHIP) begin
          cidx <= cidx_nxt;
          case (cidx)
            4'h4, 4'h5, 4'h6, 4'h7: pkt_len <= {pkt_len[23:0], dl_data};
            4'h9:    b_type        <= dl_data;
            4'hA:    b_num[15:8]   <= dl_data;
            4'hB:    b_num[7:0]    <= dl_data;
            4'hC:    b_laddr[15:8] <= dl_data;
            4'hD:    b_laddr[7:0]  <= dl_data;
            4'hE:    size_hi       <= dl_data;
            default: ;
          endcase
        end
        if (desc) begin
          cart_bank_num   <= b_num;
          cart_bank_type  <= b_type;
          cart_bank_laddr <= b_laddr;
          cart_bank_size  <= {size_hi, dl_data};
          cart_bank_raddr <= DATA_BASE + offset_al;
          cart_bank_wr    <= 1'b1;
          offset          <= offset_al;
          remaining       <= pkt_len - 32'd16;
          if (bank_count != 8'hFF) bank_count <= bank_count + 8'd1;
        end
        if (wr_mem) begin
          mem_wr    <= 1'b1;
          mem_addr  <= DATA_BASE + offset;
          mem_data  <= dl_data;
          offset    <= offset + 25'd1;
          remaining <= remaining - 32'd1;
        end
        if (ns == ERR) begin
          error         <= 1'b1;
          cart_loading  <= 1'b0;
          cart_attached <= 1'b0;
        end
        if (ns == DONE) begin
          cart_loading  <= 1'b0;
          cart_attached <= (bank_count != 8'd0) || desc;
        end
      end
    end
  end

endmodule

// File: tb/tb_crt_loader.sv
// Directed bench for crt_loader: builds CRT images byte by byte and checks descriptors, SDRAM writes and status.
module tb_crt_loader;
  logic        clk32 = 1'b0;
  logic        reset, dl_active, dl_wr;
  logic [7:0]  dl_data;
  logic        cart_loading, cart_attached, cart_bank_wr, mem_wr, error;
  logic [15:0] cart_id, cart_bank_num, cart_bank_laddr, cart_bank_size;
  logic [7:0]  cart_exrom, cart_game, cart_bank_type, mem_data, bank_count;
  logic [24:0] cart_bank_raddr, mem_addr;

  crt_loader dut (
    .clk32(clk32), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr), .dl_data(dl_data),
    .cart_loading(cart_loading), .cart_attached(cart_attached), .cart_id(cart_id),
    .cart_exrom(cart_exrom), .cart_game(cart_game), .cart_bank_num(cart_bank_num),
    .cart_bank_type(cart_bank_type), .cart_bank_laddr(cart_bank_laddr),
    .cart_bank_size(cart_bank_size), .cart_bank_raddr(cart_bank_raddr),
    .cart_bank_wr(cart_bank_wr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .bank_count(bank_count), .error(error)
  );

  always #5 clk32 = ~clk32;

  logic [158:0] all_out;
  assign all_out = {cart_loading, cart_attached, cart_id, cart_exrom, cart_game, cart_bank_num,
                    cart_bank_type, cart_bank_laddr, cart_bank_size, cart_bank_raddr, cart_bank_wr,
                    mem_addr, mem_data, mem_wr, bank_count, error};

  int checks = 0;
  int fails  = 0;
  int mem_cnt = 0, bank_cnt = 0, addr_err = 0, data_err = 0, both_err = 0;
  logic [24:0] first_addr = '0, last_addr = '0, exp_next = '0, cur_base = '0;
  logic [24:0] raddr0 = '0, raddr_last = '0;
  logic clr_req = 1'b0;
  logic [7:0] f[$];

  // Writes are checked against the address stream implied by the latest descriptor.
  always @(negedge clk32) begin
    if (clr_req) begin
      mem_cnt = 0; bank_cnt = 0; addr_err = 0; data_err = 0; both_err = 0;
      first_addr = '0; last_addr = '0; raddr0 = '0; raddr_last = '0;
    end else begin
      if (mem_wr && cart_bank_wr) both_err++;
      if (cart_bank_wr) begin
        if (bank_cnt == 0) raddr0 = cart_bank_raddr;
        raddr_last = cart_bank_raddr;
        cur_base   = cart_bank_raddr;
        exp_next   = cart_bank_raddr;
        bank_cnt++;
      end
      if (mem_wr) begin
        if (mem_cnt == 0) first_addr = mem_addr;
        last_addr = mem_addr;
        if (mem_addr !== exp_next) addr_err++;
        if (mem_data !== (8'(mem_addr - cur_base) ^ 8'h5A)) data_err++;
        exp_next = exp_next + 25'd1;
        mem_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk32); dl_wr = 1'b1; dl_data = b;
    @(negedge clk32); dl_wr = 1'b0;
  endtask

  task automatic send_all();
    logic [7:0] b;
    while (f.size() > 0) begin
      b = f.pop_front();
      send(b);
    end
  endtask

  task automatic push16(input logic [15:0] v);
    f.push_back(v[15:8]); f.push_back(v[7:0]);
  endtask

  task automatic push32(input logic [31:0] v);
    push16(v[31:16]); push16(v[15:0]);
  endtask

  task automatic push_hdr(input logic [31:0] hlen, input logic [15:0] id,
                          input logic [7:0] ex, input logic [7:0] gm, input logic bad_sig);
    logic [127:0] s;
    logic [7:0]   b;
    s = "C64 CARTRIDGE   ";
    for (int i = 0; i < 16; i++) begin
      b = s[127 - 8*i -: 8];
      if (bad_sig && i == 3) b = "X";
      f.push_back(b);
    end
    push32(hlen); push16(16'h0100); push16(id); f.push_back(ex); f.push_back(gm);
    repeat (6) f.push_back(8'h00);
    for (int i = 32; i < int'(hlen); i++) f.push_back(8'hEE);
  endtask

  task automatic push_chip(input logic [31:0] plen, input logic [15:0] bank,
                           input logic [15:0] laddr, input logic [15:0] size);
    push32(32'h43484950); push32(plen); push16(16'h0000); push16(bank); push16(laddr); push16(size);
  endtask

  task automatic push_data(input int n);
    for (int i = 0; i < n; i++) f.push_back(8'(i) ^ 8'h5A);
  endtask

  task automatic clear_mon();
    clr_req = 1'b1;
    @(posedge clk32); @(negedge clk32); #1;
    clr_req = 1'b0;
  endtask

  task automatic start();
    clear_mon();
    f.delete();
    @(negedge clk32); dl_active = 1'b1;
    repeat (2) @(negedge clk32);
  endtask

  task automatic stop();
    @(negedge clk32); dl_active = 1'b0;
    repeat (3) @(negedge clk32);
  endtask

  initial begin
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'h00;
    repeat (3) @(negedge clk32);
    check("reset_outputs", 32'(|all_out), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk32);

    // Single 8K generic cartridge
    start();
    check("t1_loading", 32'(cart_loading), 32'd1);
    push_hdr(32'h40, 16'h0000, 8'h00, 8'h01, 1'b0);
    push_chip(32'h2010, 16'h0000, 16'h8000, 16'h2000);
    push_data(8192);
    send_all();
    stop();
    check("t1_cart_id", 32'(cart_id), 32'h0);
    check("t1_exrom", 32'(cart_exrom), 32'h0);
    check("t1_game", 32'(cart_game), 32'h1);
    check("t1_bank_strobes", 32'(bank_cnt), 32'd1);
    check("t1_raddr", 32'(raddr0), 32'h0100000);
    check("t1_laddr", 32'(cart_bank_laddr), 32'h8000);
    check("t1_size", 32'(cart_bank_size), 32'h2000);
    check("t1_mem_count", 32'(mem_cnt), 32'd8192);
    check("t1_first_addr", 32'(first_addr), 32'h0100000);
    check("t1_last_addr", 32'(last_addr), 32'h0101FFF);
    check("t1_addr_seq", 32'(addr_err), 32'd0);
    check("t1_data", 32'(data_err), 32'd0);
    check("t1_no_overlap", 32'(both_err), 32'd0);
    check("t1_attached", 32'(cart_attached), 32'd1);
    check("t1_bank_count", 32'(bank_count), 32'd1);
    check("t1_loading_off", 32'(cart_loading), 32'd0);
    check("t1_error", 32'(error), 32'd0);

    // Two CHIPs, the second realigned to the next 8K boundary
    start();
    check("t2_attached_cleared", 32'(cart_attached), 32'd0);
    push_hdr(32'h40, 16'h0000, 8'h00, 8'h01, 1'b0);
    push_chip(32'h1010, 16'h0000, 16'h8000, 16'h1000);
    push_data(4096);
    push_chip(32'h2010, 16'h0001, 16'hA000, 16'h2000);
    push_data(8192);
    send_all();
    stop();
    check("t2_bank_strobes", 32'(bank_cnt), 32'd2);
    check("t2_raddr0", 32'(raddr0), 32'h0100000);
    check("t2_raddr1", 32'(raddr_last), 32'h0102000);
    check("t2_bank_num", 32'(cart_bank_num), 32'd1);
    check("t2_laddr", 32'(cart_bank_laddr), 32'hA000);
    check("t2_mem_count", 32'(mem_cnt), 32'h3000);
    check("t2_last_addr", 32'(last_addr), 32'h0103FFF);
    check("t2_addr_seq", 32'(addr_err), 32'd0);
    check("t2_data", 32'(data_err), 32'd0);
    check("t2_bank_count", 32'(bank_count), 32'd2);
    check("t2_attached", 32'(cart_attached), 32'd1);

    // Corrupt signature byte 3
    start();
    push_hdr(32'h40, 16'h0000, 8'h00, 8'h01, 1'b1);
    push_chip(32'h1010, 16'h0000, 16'h8000, 16'h1000);
    push_data(16);
    send_all();
    check("t3_error", 32'(error), 32'd1);
    check("t3_loading", 32'(cart_loading), 32'd0);
    check("t3_attached", 32'(cart_attached), 32'd0);
    check("t3_no_mem", 32'(mem_cnt), 32'd0);
    check("t3_no_bank", 32'(bank_cnt), 32'd0);
    stop();
    check("t3_error_sticky", 32'(error), 32'd1);

    // Restart with an extended header that must be skipped
    start();
    check("t4_error_cleared", 32'(error), 32'd0);
    check("t4_loading", 32'(cart_loading), 32'd1);
    push_hdr(32'h48, 16'h0013, 8'h01, 8'h00, 1'b0);
    push_chip(32'h14, 16'h0005, 16'h8000, 16'h0004);
    push_data(4);
    send_all();
    stop();
    check("t4_error", 32'(error), 32'd0);
    check("t4_cart_id", 32'(cart_id), 32'h13);
    check("t4_exrom", 32'(cart_exrom), 32'h1);
    check("t4_game", 32'(cart_game), 32'h0);
    check("t4_bank_num", 32'(cart_bank_num), 32'd5);
    check("t4_size", 32'(cart_bank_size), 32'd4);
    check("t4_raddr", 32'(raddr0), 32'h0100000);
    check("t4_mem_count", 32'(mem_cnt), 32'd4);
    check("t4_data", 32'(data_err), 32'd0);
    check("t4_attached", 32'(cart_attached), 32'd1);

    // Download ends mid-payload
    start();
    push_hdr(32'h40, 16'h0000, 8'h00, 8'h01, 1'b0);
    push_chip(32'h2010, 16'h0000, 16'h8000, 16'h2000);
    push_data(100);
    send_all();
    stop();
    check("t5_error", 32'(error), 32'd1);
    check("t5_attached", 32'(cart_attached), 32'd0);
    check("t5_loading", 32'(cart_loading), 32'd0);
    check("t5_mem_count", 32'(mem_cnt), 32'd100);
    check("t5_bank_strobes", 32'(bank_cnt), 32'd1);

    // Asynchronous reset in the middle of a payload
    start();
    push_hdr(32'h40, 16'h0000, 8'h00, 8'h01, 1'b0);
    push_chip(32'h2010, 16'h0000, 16'h8000, 16'h2000);
    push_data(50);
    send_all();
    #2;
    reset = 1'b1; dl_active = 1'b0;
    #1;
    check("t6_outputs_async", 32'(|all_out), 32'd0);
    check("t6_mem_count", 32'(mem_cnt), 32'd50);
    repeat (3) @(negedge clk32);
    reset = 1'b0;
    push_data(10);
    send_all();
    repeat (3) @(negedge clk32);
    check("t6_no_more_mem", 32'(mem_cnt), 32'd50);
    check("t6_no_more_bank", 32'(bank_cnt), 32'd1);
    check("t6_outputs_idle", 32'(|all_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
